// File: rtl/ahbl_master_stage.sv
//============================================================================
// Module   : ahbl_master_stage
// Purpose  : Per-master AHB-Lite address stage: slave decode, hold-until-grant,
//            data-phase tracking and internal ERROR default slave.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module ahbl_master_stage #(
    parameter logic [15:0] SLAVE_EN = 16'h000F
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    output logic        HREADY_M,
    output logic        HRESP_M,
    output logic [15:0] SREQ,
    output logic        SLOCK,
    input  logic [15:0] SGRANT,
    input  logic [15:0] S_HREADY,
    input  logic [15:0] S_HRESP,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [2:0]  S_HBURST,
    output logic [3:0]  S_HPROT,
    output logic [3:0]  DP_SEL
);

    localparam logic       A_IDLE  = 1'b0;
    localparam logic       A_HOLD  = 1'b1;

    localparam logic [1:0] DP_NONE = 2'd0;
    localparam logic [1:0] DP_SLV  = 2'd1;
    localparam logic [1:0] DP_ERR1 = 2'd2;
    localparam logic [1:0] DP_ERR2 = 2'd3;

    localparam logic [1:0] C_NONSEQ = 2'b10;

    logic        r_astate;
    logic        w_anext;
    logic [1:0]  r_dp;
    logic [1:0]  w_dp_next;
    logic [3:0]  r_dp_sel;
    logic [3:0]  w_sel_next;

    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [2:0]  r_hburst;
    logic [3:0]  r_hprot;
    logic        r_hlock;

    logic        w_live;
    logic        w_live_mapped;
    logic [3:0]  w_idx;
    logic        w_req;
    logic        w_accept;
    logic        w_unmapped;
    logic        w_capture;

    // A live request exists only when the master sees HREADY high; HREADY_M
    // is forced low in A_HOLD, so the master's next address is never sampled there.
    assign w_live        = HREADY_M & HTRANS[1];
    assign w_live_mapped = SLAVE_EN[HADDR[31:28]];
    assign w_idx         = (r_astate == A_HOLD) ? r_haddr[31:28] : HADDR[31:28];
    assign w_req         = (r_astate == A_HOLD) | (w_live & w_live_mapped);
    assign w_accept      = w_req & SGRANT[w_idx] & S_HREADY[w_idx];
    assign w_unmapped    = (r_astate == A_IDLE) & w_live & ~w_live_mapped;
    assign w_capture     = (r_astate == A_IDLE) & w_req & ~w_accept;
    assign DP_SEL        = r_dp_sel;

    // Address FSM: state register
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_astate <= A_IDLE;
        end else begin
            r_astate <= w_anext;
        end
    end

    // Address FSM: next state
    always_comb begin
        w_anext = r_astate;
        case (r_astate)
            A_IDLE:  if (w_capture) w_anext = A_HOLD;
            A_HOLD:  if (w_accept)  w_anext = A_IDLE;
            default: w_anext = A_IDLE;
        endcase
    end

    // Address FSM: outputs toward the arbiters and slaves
    always_comb begin
        SREQ     = 16'h0000;
        S_HADDR  = HADDR;
        S_HTRANS = HTRANS;
        S_HWRITE = HWRITE;
        S_HSIZE  = HSIZE;
        S_HBURST = HBURST;
        S_HPROT  = HPROT;
        SLOCK    = HMASTLOCK;
        if (r_astate == A_HOLD) begin
            S_HADDR  = r_haddr;
            S_HTRANS = C_NONSEQ;
            S_HWRITE = r_hwrite;
            S_HSIZE  = r_hsize;
            S_HBURST = r_hburst;
            S_HPROT  = r_hprot;
            SLOCK    = r_hlock;
        end
        if (w_req) begin
            SREQ = 16'h0001 << w_idx;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_haddr  <= 32'h0;
            r_hwrite <= 1'b0;
            r_hsize  <= 3'h0;
            r_hburst <= 3'h0;
            r_hprot  <= 4'h0;
            r_hlock  <= 1'b0;
        end else if (w_capture) begin
            r_haddr  <= HADDR;
            r_hwrite <= HWRITE;
            r_hsize  <= HSIZE;
            r_hburst <= HBURST;
            r_hprot  <= HPROT;
            r_hlock  <= HMASTLOCK;
        end
    end

    // Data-phase tracker
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_dp     <= DP_NONE;
            r_dp_sel <= 4'h0;
        end else begin
            r_dp     <= w_dp_next;
            r_dp_sel <= w_sel_next;
        end
    end

    always_comb begin
        w_dp_next  = r_dp;
        w_sel_next = r_dp_sel;
        if (w_accept) begin
            w_dp_next  = DP_SLV;
            w_sel_next = w_idx;
        end else if (w_unmapped) begin
            w_dp_next = DP_ERR1;
        end else begin
            case (r_dp)
                DP_ERR1: w_dp_next = DP_ERR2;
                DP_ERR2: w_dp_next = DP_NONE;
                DP_SLV:  if (S_HREADY[r_dp_sel]) w_dp_next = DP_NONE;
                default: w_dp_next = DP_NONE;
            endcase
        end
    end

    // Response to the master; a held transfer always stalls it
    always_comb begin
        HREADY_M = 1'b1;
        HRESP_M  = 1'b0;
        if (r_astate == A_HOLD) begin
            HREADY_M = 1'b0;
        end else begin
            case (r_dp)
                DP_SLV: begin
                    HREADY_M = S_HREADY[r_dp_sel];
                    HRESP_M  = S_HRESP[r_dp_sel];
                end
                DP_ERR1: begin
                    HREADY_M = 1'b0;
                    HRESP_M  = 1'b1;
                end
                DP_ERR2: begin
                    HREADY_M = 1'b1;
                    HRESP_M  = 1'b1;
                end
                default: begin
                    HREADY_M = 1'b1;
                    HRESP_M  = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahbl_master_stage.sv
// Directed table-driven bench for ahbl_master_stage plus a reset-during-hold sequence.
`default_nettype none

module tb_ahbl_master_stage;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic        HREADY_M;
    logic        HRESP_M;
    logic [15:0] SREQ;
    logic        SLOCK;
    logic [15:0] SGRANT;
    logic [15:0] S_HREADY;
    logic [15:0] S_HRESP;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [2:0]  S_HBURST;
    logic [3:0]  S_HPROT;
    logic [3:0]  DP_SEL;

    ahbl_master_stage #(.SLAVE_EN(16'h000F)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY_M(HREADY_M), .HRESP_M(HRESP_M), .SREQ(SREQ), .SLOCK(SLOCK),
        .SGRANT(SGRANT), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT),
        .DP_SEL(DP_SEL)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [15:0] sgrant;
        logic [15:0] shready;
        logic [15:0] shresp;
        logic        e_rdy;
        logic        e_resp;
        logic [15:0] e_sreq;
        logic [31:0] e_saddr;
        logic [1:0]  e_strans;
        logic        e_swrite;
        logic [3:0]  e_sel;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [15:0] g, input logic [15:0] r, input logic [15:0] e,
                       input logic erdy, input logic eresp, input logic [15:0] ereq,
                       input logic [31:0] esa, input logic [1:0] est, input logic esw,
                       input logic [3:0] esel);
        vec_t v;
        v.haddr = a; v.htrans = t; v.hwrite = w; v.sgrant = g; v.shready = r; v.shresp = e;
        v.e_rdy = erdy; v.e_resp = eresp; v.e_sreq = ereq; v.e_saddr = esa;
        v.e_strans = est; v.e_swrite = esw; v.e_sel = esel;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        HRESETN = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'h3; HMASTLOCK = 1'b0;
        SGRANT = 16'h0; S_HREADY = 16'hFFFF; S_HRESP = 16'h0;

        //   haddr          tr     w  sgrant   shready  shresp   rdy resp sreq     saddr          str    sw sel
        // reset state
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd0); // 0
        // immediate grant
        add(32'h1000_0000, 2'b10, 1, 16'h0002, 16'hFFFF, 16'h0000, 1, 0, 16'h0002, 32'h1000_0000, 2'b10, 1, 4'd0); // 1
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd1); // 2
        // contention: three cycles without grant, held address stays on S_HADDR
        add(32'h2000_0010, 2'b10, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h0004, 32'h2000_0010, 2'b10, 0, 4'd1); // 3
        add(32'h3000_0000, 2'b10, 1, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 16'h0004, 32'h2000_0010, 2'b10, 0, 4'd1); // 4
        add(32'h3000_0000, 2'b10, 1, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 16'h0004, 32'h2000_0010, 2'b10, 0, 4'd1); // 5
        add(32'h3000_0000, 2'b10, 1, 16'h0004, 16'hFFFF, 16'h0000, 0, 0, 16'h0004, 32'h2000_0010, 2'b10, 0, 4'd1); // 6
        // slave 2 data phase with one wait state, then burst of 4 to slave 3
        add(32'h3000_0000, 2'b10, 1, 16'h0008, 16'hFFFB, 16'h0000, 0, 0, 16'h0000, 32'h3000_0000, 2'b10, 1, 4'd2); // 7
        add(32'h3000_0000, 2'b10, 1, 16'h0008, 16'hFFFF, 16'h0000, 1, 0, 16'h0008, 32'h3000_0000, 2'b10, 1, 4'd2); // 8
        add(32'h3000_0004, 2'b11, 1, 16'h0008, 16'hFFFF, 16'h0000, 1, 0, 16'h0008, 32'h3000_0004, 2'b11, 1, 4'd3); // 9
        add(32'h3000_0008, 2'b11, 1, 16'h0008, 16'hFFFF, 16'h0000, 1, 0, 16'h0008, 32'h3000_0008, 2'b11, 1, 4'd3); // 10
        add(32'h3000_000C, 2'b11, 1, 16'h0008, 16'hFFFF, 16'h0000, 1, 0, 16'h0008, 32'h3000_000C, 2'b11, 1, 4'd3); // 11
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd3); // 12
        // unmapped: stray grants are ignored, then ERROR 0/1 and 1/1
        add(32'h8000_0000, 2'b10, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 32'h8000_0000, 2'b10, 0, 4'd3); // 13
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd3); // 14
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd3); // 15
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd3); // 16
        // slave 0 wait states with ERROR passed through
        add(32'h0000_0040, 2'b10, 0, 16'h0001, 16'hFFFF, 16'h0000, 1, 0, 16'h0001, 32'h0000_0040, 2'b10, 0, 4'd3); // 17
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFE, 16'h0001, 0, 1, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd0); // 18
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFE, 16'h0001, 0, 1, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd0); // 19
        // last slave-0 cycle (only slave 0 ready) while a new transfer to slave 1 gets captured
        add(32'h1000_0000, 2'b10, 1, 16'h0000, 16'h0001, 16'h0001, 1, 1, 16'h0002, 32'h1000_0000, 2'b10, 1, 4'd0); // 20
        add(32'h2000_0000, 2'b10, 0, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 16'h0002, 32'h1000_0000, 2'b10, 1, 4'd0); // 21
        add(32'h2000_0000, 2'b10, 0, 16'h0002, 16'hFFFF, 16'h0000, 0, 0, 16'h0002, 32'h1000_0000, 2'b10, 1, 4'd0); // 22
        add(32'h0000_0000, 2'b00, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 2'b00, 0, 4'd1); // 23

        repeat (2) @(posedge HCLK);
        #1 HRESETN = 1'b1;

        foreach (vecs[i]) begin
            @(posedge HCLK);
            #1;
            HADDR = vecs[i].haddr; HTRANS = vecs[i].htrans; HWRITE = vecs[i].hwrite;
            SGRANT = vecs[i].sgrant; S_HREADY = vecs[i].shready; S_HRESP = vecs[i].shresp;
            @(negedge HCLK);
            chk("hready_m", i, 32'(HREADY_M), 32'(vecs[i].e_rdy));
            chk("hresp_m",  i, 32'(HRESP_M),  32'(vecs[i].e_resp));
            chk("sreq",     i, 32'(SREQ),     32'(vecs[i].e_sreq));
            chk("s_haddr",  i, S_HADDR,       vecs[i].e_saddr);
            chk("s_htrans", i, 32'(S_HTRANS), 32'(vecs[i].e_strans));
            chk("s_hwrite", i, 32'(S_HWRITE), 32'(vecs[i].e_swrite));
            chk("dp_sel",   i, 32'(DP_SEL),   32'(vecs[i].e_sel));
        end

        // Reset while holding a locked transfer to slave 2
        @(posedge HCLK); #1;
        HADDR = 32'h2000_0000; HTRANS = 2'b10; HWRITE = 1'b0; HMASTLOCK = 1'b1;
        SGRANT = 16'h0000; S_HREADY = 16'hFFFF; S_HRESP = 16'h0000;
        @(negedge HCLK);
        chk("rst_seq_sreq", 100, 32'(SREQ), 32'h0004);
        chk("rst_seq_slock", 100, 32'(SLOCK), 32'h1);
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HMASTLOCK = 1'b0; HADDR = 32'h0;
        @(negedge HCLK);
        chk("rst_seq_hold_rdy", 101, 32'(HREADY_M), 32'h0);
        chk("rst_seq_hold_lock", 101, 32'(SLOCK), 32'h1);
        #1 HRESETN = 1'b0;
        #1;
        chk("rst_seq_sreq0", 102, 32'(SREQ), 32'h0);
        chk("rst_seq_rdy1", 102, 32'(HREADY_M), 32'h1);
        chk("rst_seq_resp0", 102, 32'(HRESP_M), 32'h0);
        @(posedge HCLK); #1;
        HRESETN = 1'b1;
        @(posedge HCLK); #1;
        HADDR = 32'h1000_0000; HTRANS = 2'b10; HWRITE = 1'b1; SGRANT = 16'h0002;
        @(negedge HCLK);
        chk("rst_seq_new_sreq", 103, 32'(SREQ), 32'h0002);
        chk("rst_seq_new_saddr", 103, S_HADDR, 32'h1000_0000);
        chk("rst_seq_new_dpsel", 103, 32'(DP_SEL), 32'h0);
        @(posedge HCLK); #1;
        HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; SGRANT = 16'h0;
        @(negedge HCLK);
        chk("rst_seq_dp_rdy", 104, 32'(HREADY_M), 32'h1);
        chk("rst_seq_dp_sel", 104, 32'(DP_SEL), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahbl_master_stage.md
# ahbl_master_stage

Per-master address stage of the 2-master AHB-Lite bus matrix. Sits between one master port and the per-slave arbiters. It decodes the master's address phase into a one-hot slave request and holds the transfer until the target slave's arbiter grants it and the slave is ready. It tracks the data phase, returns HREADY/HRESP to the master, and answers unmapped addresses with a two-cycle ERROR from an internal default slave.

## Interface
- SLAVE_EN, 16'h000F, enable mask; bit i set = slave i (HADDR[31:28]==i) is mapped.
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETN  in  1  reset, asynchronous, active-low.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK  in  1/3/3/4/1  master control.
- HREADY_M  out  1  ready to master.
- HRESP_M  out  1  response to master (1 = ERROR).
- SREQ  out  16  per-slave request to arbiters (one-hot or zero).
- SLOCK  out  1  lock qualifier to arbiters, = HMASTLOCK of the forwarded transfer.
- SGRANT  in  16  grant for this master from each slave arbiter.
- S_HREADY  in  16  HREADYOUT of each slave.
- S_HRESP  in  16  HRESP of each slave.
- S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT  out  32/2/1/3/3/4  forwarded address phase.
- DP_SEL  out  4  slave index of current data phase; drives the external HRDATA mux.

## Operation
- Live request: HREADY_M=1, HTRANS[1]=1. idx = HADDR[31:28]. Mapped if SLAVE_EN[idx].
- Address FSM has two states:
  - A_IDLE: outputs forward the live inputs.
  - A_HOLD: outputs come from hold registers, and S_HTRANS is forced to 2'b10 (NONSEQ).
- SREQ[idx]=1 for a mapped request: the live request in A_IDLE, the held one in A_HOLD. Otherwise SREQ=0.
- Accept = SREQ[idx] & SGRANT[idx] & S_HREADY[idx].
- A_IDLE transitions:
  - Mapped live request, not accepted: capture all address/control into hold registers, go to A_HOLD.
  - Mapped live request, accepted: stay in A_IDLE.
  - Unmapped live request: stay in A_IDLE, no SREQ, start the default-slave data phase.
  - Any other case: stay in A_IDLE.
- A_HOLD: on Accept go to A_IDLE. While in A_HOLD the master's next address is not sampled, because HREADY_M=0.
- Data-phase register, with states DP_NONE, DP_SLV, DP_ERR1, DP_ERR2:
  - Accept: DP_SLV, DP_SEL<=idx.
  - Unmapped live request: DP_ERR1.
  - DP_ERR1: next state DP_ERR2.
  - DP_ERR2, or DP_SLV with S_HREADY[DP_SEL]=1 and no new Accept/error: DP_NONE.
  - Live IDLE/BUSY with HREADY_M=1: DP_NONE.
- HREADY_M / HRESP_M by state:
  - A_HOLD: 0 / 0.
  - A_IDLE with DP_SLV: S_HREADY[DP_SEL] / S_HRESP[DP_SEL].
  - DP_ERR1: 0 / 1.
  - DP_ERR2: 1 / 1.
  - DP_NONE: 1 / 0.
- Both cases in which a transfer enters A_HOLD are covered:
  - A transfer placed in A_HOLD after its predecessor's data phase completed is seen by the master as its current data phase, so HREADY_M=0 stalls it.
  - A transfer captured on the last cycle of DP_SLV or DP_ERR2 is also stalled.

## Timing
- Reset:
  - A_IDLE, DP_NONE, DP_SEL=0, hold registers 0.
  - HREADY_M=1, HRESP_M=0, SREQ=0.
  - Reset mid-transfer abandons any held transfer.
- Zero added latency when granted immediately. The address reaches the slave in the same cycle, and the data phase starts the next cycle.
- Each cycle spent waiting in A_HOLD adds exactly one wait state to the master.
- Unmapped access: exactly two data-phase cycles, ERROR/low-ready then ERROR/high-ready.
- SREQ, S_* and HREADY_M are combinational from inputs and state. The only registers are the address FSM, the hold registers and the data-phase state/DP_SEL.
- SGRANT asserted without SREQ is ignored.
- S_HREADY of non-selected slaves does not affect HREADY_M.

## Test plan
- Immediate grant: NONSEQ write to 0x1000_0000, SGRANT[1]=1, S_HREADY=all 1 → SREQ=16'h0002 that cycle; next cycle DP_SEL=1, HREADY_M=1, HRESP_M=0.
- Contention: read 0x2000_0010, SGRANT[2]=0 for 3 cycles → A_HOLD; S_HADDR stays 0x2000_0010 while HADDR changes; HREADY_M=0 for 3 cycles; on grant, the data phase completes with slave 2's ready.
- Unmapped: NONSEQ to 0x8000_0000 with SLAVE_EN=16'h000F → SREQ=0; next two cycles HREADY_M/HRESP_M = 0/1 then 1/1.
- Slave wait states: S_HREADY[0]=0 for 2 cycles during DP_SLV to slave 0 → HREADY_M=0 for 2 cycles; S_HRESP[0]=1 is passed through.
- Back-to-back pipelining: burst of 4 SEQ to slave 3 with continuous grant → four consecutive HREADY_M=1 data phases, with DP_SEL=3 in each.
- Reset in A_HOLD: assert HRESETN=0 mid-hold → SREQ=0, HREADY_M=1 immediately; after release, a fresh NONSEQ is accepted normally.
